// File: rtl/fir_mac_sequencer.sv
// FIR front-end: sequences NTAPS delay-line/coefficient pairs into an external MAC, then scales and saturates the sum.
// One sample every NTAPS+4 cycles; sample_ready is low while a computation is in flight, so upstream must hold sample_valid.
module fir_mac_sequencer #(
   parameter int NTAPS      = 8,
   parameter int COEF_SHIFT = 15
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic signed [15:0]       sample_in,
   input  logic                     sample_valid,
   output logic                     sample_ready,
   input  logic                     coef_we,
   input  logic [$clog2(NTAPS)-1:0] coef_addr,
   input  logic signed [15:0]       coef_data,
   output logic signed [15:0]       mac_a,
   output logic signed [15:0]       mac_b,
   output logic                     mac_ce,
   output logic                     mac_rst,
   input  logic signed [31:0]       mac_result,
   output logic signed [15:0]       sample_out,
   output logic                     out_valid
);
   localparam int AW = $clog2(NTAPS);

   typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;

   state_t               state, state_nxt;
   logic signed [15:0]   delay [NTAPS];
   logic signed [15:0]   coef  [NTAPS];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        newest;
   logic [AW-1:0]        k;
   logic [AW-1:0]        rd_idx;
   logic signed [31:0]   shifted;
   logic signed [15:0]   y_sat;

   // Walk backwards in time from the newest sample; the power-of-two width does the wrap.
   assign rd_idx  = newest - k;
   assign shifted = mac_result >>> COEF_SHIFT;

   always_comb begin
      if (shifted > 32'sd32767)
         y_sat = 16'sh7FFF;
      else if (shifted < -32'sd32768)
         y_sat = 16'sh8000;
      else
         y_sat = shifted[15:0];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (sample_valid) state_nxt = CLEAR;
         CLEAR: state_nxt = RUN;
         RUN:   if (k == AW'(NTAPS - 1)) state_nxt = DRAIN;
         DRAIN: if (k == AW'(1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      sample_ready = 1'b0;
      mac_ce       = 1'b0;
      mac_rst      = 1'b0;
      mac_a        = '0;
      mac_b        = '0;
      if (!reset) begin
         sample_ready = (state == IDLE);
         mac_rst      = (state != CLEAR);
         if (state == RUN) begin
            mac_ce = 1'b1;
            mac_a  = delay[rd_idx];
            mac_b  = coef[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         newest     <= '0;
         k          <= '0;
         sample_out <= '0;
         out_valid  <= 1'b0;
         for (int i = 0; i < NTAPS; i++) begin
            delay[i] <= '0;
            coef[i]  <= '0;
         end
      end else begin
         state     <= state_nxt;
         out_valid <= 1'b0;
         // k is the tap index in RUN and the drain-cycle counter in DRAIN.
         if (state != state_nxt)
            k <= '0;
         else if (state == RUN || state == DRAIN)
            k <= k + 1'b1;
         if (state == IDLE && coef_we)
            coef[coef_addr] <= coef_data;
         if (state == IDLE && sample_valid) begin
            delay[wr_ptr] <= sample_in;
            newest        <= wr_ptr;
            wr_ptr        <= wr_ptr + 1'b1;
         end
         if (state == DRAIN && k == AW'(1)) begin
            sample_out <= y_sat;
            out_valid  <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with a behavioural MAC (input register stage feeding the accumulator).
module tb_fir_mac_sequencer;
   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic signed [15:0] sample_in = '0;
   logic               sample_valid = 1'b0;
   logic               sample_ready;
   logic               coef_we = 1'b0;
   logic [2:0]         coef_addr = '0;
   logic signed [15:0] coef_data = '0;
   logic signed [15:0] mac_a, mac_b;
   logic               mac_ce, mac_rst;
   logic signed [31:0] mac_result;
   logic signed [15:0] sample_out;
   logic               out_valid;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fir_mac_sequencer #(.NTAPS(8), .COEF_SHIFT(15)) dut (
      .clk(clk), .reset(reset),
      .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .mac_a(mac_a), .mac_b(mac_b), .mac_ce(mac_ce), .mac_rst(mac_rst),
      .mac_result(mac_result),
      .sample_out(sample_out), .out_valid(out_valid)
   );

   logic signed [15:0] a_r = '0, b_r = '0;
   logic               ce_r = 1'b0;
   logic signed [31:0] acc = '0;
   assign mac_result = acc;

   always @(posedge clk) begin
      if (!mac_rst) begin
         acc  <= '0;
         ce_r <= 1'b0;
         a_r  <= '0;
         b_r  <= '0;
      end else begin
         ce_r <= mac_ce;
         a_r  <= mac_a;
         b_r  <= mac_b;
         if (ce_r) acc <= acc + a_r * b_r;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sample_valid = 1'b0;
      coef_we = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic wr_coef(input int a, input logic [15:0] d);
      coef_we   = 1'b1;
      coef_addr = a[2:0];
      coef_data = d;
      tick();
      coef_we   = 1'b0;
   endtask

   task automatic wait_out(input string tag, output logic signed [15:0] y);
      int n;
      n = 0;
      while (!out_valid && n < 30) begin
         tick();
         n++;
      end
      check({tag, "_out_seen"}, 32'(out_valid), 32'd1);
      y = sample_out;
   endtask

   // Accept one sample (optionally with a same-cycle coefficient write) and return its output.
   task automatic push(input string tag, input logic signed [15:0] s, input logic we,
                       input int wa, input logic [15:0] wd, output logic signed [15:0] y);
      int n;
      n = 0;
      while (!sample_ready && n < 30) begin
         tick();
         n++;
      end
      check({tag, "_ready"}, 32'(sample_ready), 32'd1);
      sample_valid = 1'b1;
      sample_in    = s;
      coef_we      = we;
      coef_addr    = wa[2:0];
      coef_data    = wd;
      tick();
      sample_valid = 1'b0;
      coef_we      = 1'b0;
      n = 0;
      while (!out_valid && n < 30) begin
         tick();
         n++;
      end
      check({tag, "_latency"}, n, 11);
      check({tag, "_out_seen"}, 32'(out_valid), 32'd1);
      y = sample_out;
   endtask

   initial begin
      logic signed [15:0] y;
      int ov_cnt;

      // Reset behaviour
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_mac_rst", 32'(mac_rst), 32'd0);
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_ready", 32'(sample_ready), 32'd0);
      end
      reset = 1'b0;
      tick();
      check("post_rst_ready", 32'(sample_ready), 32'd1);
      check("post_rst_mac_ce", 32'(mac_ce), 32'd0);
      check("post_rst_sample_out", sample_out, 0);

      // Impulse response
      for (int i = 0; i < 8; i++) wr_coef(i, 16'h4000);
      push("imp0", 16'sd1000, 1'b0, 0, 16'h0, y);
      check("imp_y0", y, 500);
      for (int i = 1; i < 12; i++) begin
         push("imp", 16'sd0, 1'b0, 0, 16'h0, y);
         check("imp_y", y, (i < 8) ? 500 : 0);
      end
      tick();

      // Continuous sample_valid: cadence, output timing, MAC enable window
      sample_valid = 1'b1;
      sample_in    = 16'sd5;
      for (int c = 0; c < 48; c++) begin
         check("hs_ready", 32'(sample_ready), 32'((c % 12) == 0));
         check("hs_out_valid", 32'(out_valid), 32'(((c % 12) == 0) && (c > 0)));
         check("hs_mac_ce", 32'(mac_ce), 32'(((c % 12) >= 2) && ((c % 12) <= 9)));
         tick();
      end
      sample_valid = 1'b0;
      check("hs_last_out_valid", 32'(out_valid), 32'd1);
      tick();

      // Saturation
      do_reset();
      wr_coef(0, 16'h7FFF);
      wr_coef(1, 16'h7FFF);
      push("sat_p0", 16'sd30000, 1'b0, 0, 16'h0, y);
      check("sat_p0_y", y, 29999);
      push("sat_p1", 16'sd30000, 1'b0, 0, 16'h0, y);
      check("sat_pos_y", y, 32767);
      push("sat_n0", -16'sd30000, 1'b0, 0, 16'h0, y);
      check("sat_n0_y", y, 0);
      push("sat_n1", -16'sd30000, 1'b0, 0, 16'h0, y);
      check("sat_neg_y", y, -32768);

      // Reset in the middle of RUN
      do_reset();
      for (int i = 0; i < 8; i++) wr_coef(i, 16'h4000);
      sample_valid = 1'b1;
      sample_in    = 16'sd1000;
      tick();
      sample_valid = 1'b0;
      repeat (4) tick();
      check("mid_in_run_ce", 32'(mac_ce), 32'd1);
      reset = 1'b1;
      ov_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (out_valid) ov_cnt++;
      end
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (out_valid) ov_cnt++;
      end
      check("mid_no_out_valid", ov_cnt, 0);
      for (int i = 0; i < 8; i++) wr_coef(i, 16'h4000);
      push("mid_zero", 16'sd0, 1'b0, 0, 16'h0, y);
      check("mid_zero_y", y, 0);

      // Coefficient write during RUN is ignored
      do_reset();
      wr_coef(0, 16'h4000);
      sample_valid = 1'b1;
      sample_in    = 16'sd1000;
      tick();
      sample_valid = 1'b0;
      tick();
      tick();
      check("cw_in_run", 32'(mac_ce), 32'd1);
      coef_we   = 1'b1;
      coef_addr = 3'd0;
      coef_data = 16'h7FFF;
      tick();
      coef_we = 1'b0;
      wait_out("cw_run", y);
      check("cw_run_y", y, 500);
      push("cw_next", 16'sd1000, 1'b0, 0, 16'h0, y);
      check("cw_next_y", y, 500);

      // Coefficient write in the accepting cycle is visible to that sample
      do_reset();
      push("cw_same", 16'sd2000, 1'b1, 0, 16'h7FFF, y);
      check("cw_same_y", y, 1999);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
